zerocross_detector_v2: RTL
==========================

ZEROCROSS_DETECTOR_V2 -- requirements
Module: zerocross_detector_v2

Interface
REQ-001 Parameter NUM_CHANNELS, default 16: samples per clock, ch0 earliest, ch(N-1) latest.
REQ-002 Parameter DATA_WIDTH, default 20: signed two's-complement width per sample (Q16.4).
REQ-003 Parameter THRESH_WIDTH, default 16: unsigned hysteresis threshold width; SHALL be less than DATA_WIDTH.
REQ-004 Parameter HOLD_WIDTH, default 8: holdoff counter width.
REQ-005 Parameter CNT_WIDTH, default 32: event counter width.
REQ-006 clk  in  1  single clock for all logic.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 valid_in  in  1  diff_in qualifier.
REQ-009 diff_in  in  NUM_CHANNELS*DATA_WIDTH  packed samples, ch g at bits [(g+1)*DATA_WIDTH-1 : g*DATA_WIDTH].
REQ-010 mode  in  2  00 both directions, 01 rising only, 10 falling only, 11 detection disabled.
REQ-011 hyst_thresh  in  THRESH_WIDTH  deadband half-width T.
REQ-012 holdoff  in  HOLD_WIDTH  number of valid cycles to suppress after a reported event.
REQ-013 clear  in  1  synchronous pulse that zeroes event_count and the holdoff counter.
REQ-014 zero_mask / rise_mask / fall_mask  out  NUM_CHANNELS each  reported crossings per boundary.
REQ-015 any_event  out  1 ; first_idx  out  clog2(NUM_CHANNELS)  lowest set bit of zero_mask.
REQ-016 event_count  out  CNT_WIDTH ; valid_out  out  1.

Function
REQ-017 Classification per sample x: POS if x > +T, NEG if x < -T (signed compare, at least DATA_WIDTH+1 bits), otherwise HOLD.
REQ-018 Hysteresis state polarity: a POS or NEG sample sets the state; a HOLD sample keeps the previous state.
- The state chains ch0 -> ch(N-1) within a cycle.
- The state carries from ch(N-1) to ch0 of the next valid cycle.
REQ-019 Boundary k SHALL flag rise when the state goes NEG->POS at sample k, and fall when it goes POS->NEG.
REQ-020 Boundary 0 SHALL compare against the final state of the previous valid cycle, regardless of how many invalid cycles separate the two.
REQ-021 A known flag, cleared by reset, SHALL be set by the first POS/NEG sample.
- That first sample SHALL set the state without producing an event.
- Samples seen while the flag is clear SHALL produce no events.
REQ-022 Cycles with valid_in=0 SHALL NOT update the hysteresis state, the known flag or the holdoff counter.
REQ-023 mode, hyst_thresh and holdoff SHALL be captured with each valid_in beat and travel down the pipeline with that beat's data.
REQ-024 Mode filter on the raw masks:
- 01 forces fall_mask to 0; 10 forces rise_mask to 0; 11 forces both to 0.
- zero_mask = rise_mask OR fall_mask after filtering.
- Hysteresis state SHALL track in all modes.
REQ-025 Holdoff:
- When a valid output beat has any_event=1, the holdoff counter SHALL load holdoff.
- Each subsequent valid beat with counter>0 SHALL force all masks to 0 and decrement the counter.
- holdoff=0 means no suppression.
REQ-026 Latency: valid_out and all masks SHALL appear exactly 3 clk after the valid_in beat; fully pipelined, one beat per clock, no backpressure.
REQ-027 When valid_out=0: masks=0, any_event=0, first_idx=0.
REQ-028 event_count SHALL add popcount(zero_mask) on each valid output beat and saturate at 2^CNT_WIDTH-1.
REQ-029 clear SHALL take priority over a same-cycle increment or holdoff load: count becomes 0, holdoff counter becomes 0, and that beat is not counted.
REQ-030 first_idx SHALL be 0 when zero_mask=0.

Reset
REQ-031 On rst=1, asynchronously:
- All outputs, pipeline valids, the holdoff counter and event_count go to 0.
- The known flag clears and the hysteresis state goes to NEG.
REQ-032 Reset asserted mid-stream SHALL discard in-flight beats; no valid_out SHALL appear for beats accepted before reset release.

Verification
REQ-033 T=0, mode=00; beat A all ch=+5, then beat B ch0..7=+5, ch8..15=-5 -> B output: zero_mask=0x0100, fall_mask=0x0100, first_idx=8, event_count=1; A output: mask 0 (first-sample rule).
REQ-034 T=10, samples alternating +8/-8 after the state is established POS -> no events (deadband); a single -11 at ch3 -> fall_mask=0x0008.
REQ-035 State POS at ch15 of one beat, 5 invalid cycles, then next beat ch0=-20 (T=10) -> zero_mask=0x0001.
REQ-036 mode=01 with a fall at ch2 and a rise at ch9 -> zero_mask=0x0200, rise_mask=0x0200, fall_mask=0.
REQ-037 holdoff=2, an event on beat n, events present on beats n+1..n+3 -> masks 0 on n+1 and n+2, reported on n+3.
REQ-038 event_count preloaded near saturation via repeated events with CNT_WIDTH=4 -> holds at 15; clear coincident with an event -> 0.

Source files
------------

// File: rtl/zerocross_detector_v2.sv
// Multi-channel zero-crossing detector with hysteresis, direction filter,
// post-event holdoff and a saturating event counter.
// Three register stages: input capture (p0), hysteresis chain (p1),
// filter/holdoff/count (output registers).
module zerocross_detector_v2 #(
   parameter int NUM_CHANNELS = 16,
   parameter int DATA_WIDTH   = 20,
   parameter int THRESH_WIDTH = 16,
   parameter int HOLD_WIDTH   = 8,
   parameter int CNT_WIDTH    = 32,
   localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               valid_in,
   input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] diff_in,
   input  logic [1:0]                         mode,
   input  logic [THRESH_WIDTH-1:0]            hyst_thresh,
   input  logic [HOLD_WIDTH-1:0]              holdoff,
   input  logic                               clear,
   output logic [NUM_CHANNELS-1:0]            zero_mask,
   output logic [NUM_CHANNELS-1:0]            rise_mask,
   output logic [NUM_CHANNELS-1:0]            fall_mask,
   output logic                               any_event,
   output logic [IDX_W-1:0]                   first_idx,
   output logic [CNT_WIDTH-1:0]               event_count,
   output logic                               valid_out
);

   localparam int PC_W  = $clog2(NUM_CHANNELS + 1);
   localparam int SUM_W = ((CNT_WIDTH > PC_W) ? CNT_WIDTH : PC_W) + 1;

   // Number of set bits in a channel mask.
   function automatic logic [PC_W-1:0] popcount(input logic [NUM_CHANNELS-1:0] m);
      logic [PC_W-1:0] r;
      r = '0;
      for (int g = 0; g < NUM_CHANNELS; g++) r = r + PC_W'(m[g]);
      return r;
   endfunction

   // Counter add that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [PC_W-1:0]      b);
      logic [SUM_W-1:0] s;
      logic [SUM_W-1:0] lim;
      s   = SUM_W'(a) + SUM_W'(b);
      lim = SUM_W'({CNT_WIDTH{1'b1}});
      if (s > lim) return {CNT_WIDTH{1'b1}};
      return s[CNT_WIDTH-1:0];
   endfunction

   // Index of the lowest set bit; 0 for an empty mask.
   function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_CHANNELS-1:0] m);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int g = NUM_CHANNELS - 1; g >= 0; g--) if (m[g]) r = IDX_W'(g);
      return r;
   endfunction

   // ---- stage p0: input capture ----
   logic                               vld_p0;
   logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_p0;
   logic [1:0]                         mode_p0;
   logic [THRESH_WIDTH-1:0]            thresh_p0;
   logic [HOLD_WIDTH-1:0]              hold_p0;

   // Beat qualifier for the capture stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) vld_p0 <= 1'b0;
      else     vld_p0 <= valid_in;
   end

   // Samples and per-beat controls travel together; no reset needed on data.
   always_ff @(posedge clk) begin
      data_p0   <= diff_in;
      mode_p0   <= mode;
      thresh_p0 <= hyst_thresh;
      hold_p0   <= holdoff;
   end

   // ---- stage p1: classification and hysteresis chain ----
   logic                           state_q;   // 1 = POS, 0 = NEG
   logic                           known_q;
   logic                           st_c, kn_c;
   logic [NUM_CHANNELS-1:0]        rise_c, fall_c;
   logic signed [DATA_WIDTH:0]     t_ext, neg_t, x_ext;
   logic [DATA_WIDTH-1:0]          s_raw;

   // Walk ch0 -> chN-1, seeded by the last state of the previous valid beat.
   always_comb begin
      st_c   = state_q;
      kn_c   = known_q;
      rise_c = '0;
      fall_c = '0;
      s_raw  = '0;
      x_ext  = '0;
      t_ext  = signed'((DATA_WIDTH + 1)'(thresh_p0));
      neg_t  = -t_ext;
      for (int g = 0; g < NUM_CHANNELS; g++) begin
         s_raw = data_p0[g*DATA_WIDTH +: DATA_WIDTH];
         x_ext = {s_raw[DATA_WIDTH-1], s_raw};
         if (x_ext > t_ext) begin
            if (kn_c && !st_c) rise_c[g] = 1'b1;
            st_c = 1'b1;
            kn_c = 1'b1;
         end else if (x_ext < neg_t) begin
            if (kn_c && st_c) fall_c[g] = 1'b1;
            st_c = 1'b0;
            kn_c = 1'b1;
         end
      end
   end

   // Hysteresis state advances only on valid beats, in every mode.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= 1'b0;
         known_q <= 1'b0;
      end else if (vld_p0) begin
         state_q <= st_c;
         known_q <= kn_c;
      end
   end

   logic                    vld_p1;
   logic [NUM_CHANNELS-1:0] rise_p1, fall_p1;
   logic [1:0]              mode_p1;
   logic [HOLD_WIDTH-1:0]   hold_p1;

   // Beat qualifier for the hysteresis stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) vld_p1 <= 1'b0;
      else     vld_p1 <= vld_p0;
   end

   // Raw crossing masks plus the controls still needed downstream.
   always_ff @(posedge clk) begin
      rise_p1 <= rise_c;
      fall_p1 <= fall_c;
      mode_p1 <= mode_p0;
      hold_p1 <= hold_p0;
   end

   // ---- stage p2: direction filter, holdoff, counting ----
   logic [HOLD_WIDTH-1:0]   hold_cnt;
   logic                    suppress;
   logic [NUM_CHANNELS-1:0] rise_s, fall_s, zero_s;

   // mode[1] blocks rising edges, mode[0] blocks falling edges; holdoff blanks all.
   always_comb begin
      suppress = (hold_cnt != '0);
      rise_s   = (mode_p1[1] || suppress) ? '0 : rise_p1;
      fall_s   = (mode_p1[0] || suppress) ? '0 : fall_p1;
      zero_s   = rise_s | fall_s;
   end

   // Output registers; everything reads zero on idle cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_out <= 1'b0;
         zero_mask <= '0;
         rise_mask <= '0;
         fall_mask <= '0;
         any_event <= 1'b0;
         first_idx <= '0;
      end else begin
         valid_out <= vld_p1;
         if (vld_p1) begin
            zero_mask <= zero_s;
            rise_mask <= rise_s;
            fall_mask <= fall_s;
            any_event <= |zero_s;
            first_idx <= lowest_idx(zero_s);
         end else begin
            zero_mask <= '0;
            rise_mask <= '0;
            fall_mask <= '0;
            any_event <= 1'b0;
            first_idx <= '0;
         end
      end
   end

   // Holdoff: count down on suppressed beats, reload from the beat that reported.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_cnt <= '0;
      end else if (clear) begin
         hold_cnt <= '0;
      end else if (vld_p1) begin
         if (suppress)        hold_cnt <= hold_cnt - HOLD_WIDTH'(1);
         else if (|zero_s)    hold_cnt <= hold_p1;
      end
   end

   // Saturating tally of reported crossings; clear wins over this beat's add.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         event_count <= '0;
      else if (clear)  event_count <= '0;
      else if (vld_p1) event_count <= sat_add(event_count, popcount(zero_s));
   end

endmodule
